// File: rtl/csa_mult_pkg.sv
// Shared types and parameter-legality helpers for the carry-save sequential multiplier.
package csa_mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StFinal,
        StDone
    } state_e;

    localparam int unsigned MinWidth = 4;

    function automatic bit width_ok(input int unsigned w);
        return (w >= MinWidth) && ((w % 2) == 0);
    endfunction

    function automatic bit pp_ok(input int unsigned w, input int unsigned p);
        return ((p == 1) || (p == 2) || (p == 4) || (p == 8)) && ((w % p) == 0);
    endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save row; carry is pre-shifted so sum + carry equals x + y + z (mod 2^W).
module csa_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_seq_multiplier.sv
// Sequential sign-magnitude multiplier: PP_PER_CYCLE partial products per cycle are folded
// into a redundant sum/carry pair, then resolved with a single carry-propagate add.
module csa_seq_multiplier
    import csa_mult_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PP_PER_CYCLE = 4,
    parameter int unsigned TAG_W        = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned N     = WIDTH / PP_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    if (!width_ok(WIDTH) || !pp_ok(WIDTH, PP_PER_CYCLE) || (TAG_W < 1)) begin : g_bad_params
        $error("csa_seq_multiplier: illegal WIDTH/PP_PER_CYCLE/TAG_W combination");
    end

    state_e             state_q, state_d;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [PW-1:0]      sum_q, carry_q, result_q;
    logic               neg_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [PW-1:0]      total, final_val;

    logic [PW-1:0] row_s [PP_PER_CYCLE+1];
    logic [PW-1:0] row_c [PP_PER_CYCLE+1];

    assign accept = in_valid && (state_q == StIdle) && !flush;

    // Unsigned WIDTH-bit magnitudes keep the most-negative operand exact.
    assign a_neg = in_signed && in_a[WIDTH-1];
    assign b_neg = in_signed && in_b[WIDTH-1];
    assign a_mag = a_neg ? -in_a : in_a;
    assign b_mag = b_neg ? -in_b : in_b;

    assign row_s[0] = sum_q;
    assign row_c[0] = carry_q;

    // mcand_q is pre-shifted by the step offset, so row k only adds its local shift.
    for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_rows
        logic [PW-1:0] pp;
        assign pp = mplier_q[k] ? (mcand_q << k) : '0;

        csa_row #(
            .W (PW)
        ) u_row (
            .x     (row_s[k]),
            .y     (row_c[k]),
            .z     (pp),
            .sum   (row_s[k+1]),
            .carry (row_c[k+1])
        );
    end

    assign total     = sum_q + carry_q;
    assign final_val = neg_q ? -total : total;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StCompute;
            end
            StCompute: begin
                if (cnt_q == CNT_W'(N - 1)) state_d = StFinal;
            end
            StFinal: state_d = StDone;
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            tag_q    <= in_tag;
            sum_q    <= '0;
            carry_q  <= '0;
            cnt_q    <= '0;
        end else if (!flush && (state_q == StCompute)) begin
            sum_q    <= row_s[PP_PER_CYCLE];
            carry_q  <= row_c[PP_PER_CYCLE];
            mcand_q  <= mcand_q << PP_PER_CYCLE;
            mplier_q <= mplier_q >> PP_PER_CYCLE;
            cnt_q    <= cnt_q + CNT_W'(1);
        end else if (!flush && (state_q == StFinal)) begin
            result_q <= final_val;
        end
    end

    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: doc/csa_seq_multiplier.md
CSA_SEQ_MULTIPLIER -- requirements
Module: csa_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be even and >= 4.
REQ-002 Parameter PP_PER_CYCLE, default 4: partial products compressed per cycle; SHALL divide WIDTH; legal values 1, 2, 4, 8.
REQ-003 Parameter TAG_W, default 5: reservation-station tag width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_a  input  WIDTH  multiplicand.
REQ-009 in_b  input  WIDTH  multiplier.
REQ-010 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 in_tag  input  TAG_W  tag carried to the result.
REQ-012 flush  input  1  abort any in-flight operation.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_result  output  2*WIDTH  full product.
REQ-016 out_tag  output  TAG_W  tag of the result.

Function
REQ-017 Operation: out_result SHALL equal in_a*in_b mod 2^(2*WIDTH), interpreted per in_signed.
REQ-018 States: IDLE, COMPUTE, FINAL, DONE.
REQ-019 in_ready SHALL be 1 exactly in IDLE; acceptance = in_valid & in_ready at a clock edge.
REQ-020 On acceptance: latch |a|, |b|, result sign (a_neg XOR b_neg when signed, else 0), and tag; clear sum and carry registers (2*WIDTH each); clear step counter; go to COMPUTE.
REQ-021 COMPUTE: each cycle add PP_PER_CYCLE shifted partial products (|a| AND b-bit, shifted by bit index) into sum/carry through a chain of PP_PER_CYCLE 3:2 compressor rows; no carry propagation.
REQ-022 COMPUTE SHALL last exactly N = WIDTH/PP_PER_CYCLE cycles, counter 0..N-1; after the last step go to FINAL.
REQ-023 FINAL: one cycle; carry-propagate add sum+carry, conditionally negate per latched sign, register into out_result; go to DONE.
REQ-024 Latency: out_valid SHALL rise N+2 cycles after the acceptance edge (WIDTH=32, P=4: 10 cycles).
REQ-025 DONE: out_valid=1; out_result and out_tag held stable until out_ready=1; on out_valid & out_ready go to IDLE (no same-cycle accept).
REQ-026 flush=1 at any edge SHALL force IDLE, clear out_valid and discard the operation; in_valid with flush in IDLE SHALL NOT be accepted.
REQ-027 Inputs SHALL be ignored outside IDLE; in_a/in_b changes after acceptance SHALL not affect the result.
REQ-028 Signed boundary: most-negative operand magnitude (2^(WIDTH-1)) SHALL be handled exactly by using WIDTH-bit unsigned magnitude.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, out_valid=0, out_result=0, out_tag=0, counter=0, sum=carry=0, regardless of state; rst has priority over flush.
REQ-030 in_ready SHALL read 1 in the first cycle after reset release.

Structure
REQ-031 Shared package csa_mult_pkg SHALL hold the state enum and the legal-parameter check constants.
REQ-032 One sub-module csa_row (parametrised-width 3:2 carry-save row of full adders, carry output shifted left one bit) SHALL be instantiated PP_PER_CYCLE times.
REQ-033 Illegal parameters SHALL cause an elaboration-time error.

Verification (WIDTH=32, PP_PER_CYCLE=4, TAG_W=5)
REQ-034 Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, tag=7 -> out_valid 10 cycles after accept, result 0xFFFFFFFE00000001, tag 7.
REQ-035 Signed: a=-3, b=5, signed=1 -> 0xFFFFFFFFFFFFFFF1; a=0x80000000, b=0x80000000 signed -> 0x4000000000000000.
REQ-036 Backpressure: out_ready=0 for 5 cycles after out_valid -> result/tag stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-037 Flush at COMPUTE step 3 -> out_valid never rises; next request 0x12345678*0x10 returns 0x0000000123456780.
REQ-038 rst asserted in FINAL -> next cycle out_valid=0, out_result=0, in_ready=1.
REQ-039 Random: 10k mixed signed/unsigned requests with random out_ready vs reference model, zero mismatches.
